miriscv_mem_arbiter: RTL and testbench

//   Shares the single-port data RAM between instruction fetch (I) and load/store unit (D).

---
 rtl/miriscv_mem_pkg.sv | 16 +
 rtl/miriscv_mem_arb_pick.sv | 55 +++++
 rtl/miriscv_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_miriscv_mem_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_mem_pkg.sv
// Shared constants for the miriscv data-RAM arbiter: access size codes and FSM encoding.
package miriscv_mem_pkg;

  localparam logic [2:0] MEM_SIZE_SB = 3'd0;
  localparam logic [2:0] MEM_SIZE_SH = 3'd1;
  localparam logic [2:0] MEM_SIZE_W  = 3'd2;
  localparam logic [2:0] MEM_SIZE_UB = 3'd4;
  localparam logic [2:0] MEM_SIZE_UH = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_I = 2'd1,
    ACC_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/miriscv_mem_arb_pick.sv
// Winner selection between instruction fetch and load/store: fixed D priority with an
// anti-starvation counter, or round-robin. gnt[0] = I, gnt[1] = D.
module miriscv_mem_arb_pick
  import miriscv_mem_pkg::*;
#(
  parameter bit          PRIO_DATA    = 1'b1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_req,
  input  logic       data_req,
  input  logic       update,
  output logic [1:0] gnt
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             last_i;

  always_comb begin
    gnt = 2'b00;
    if (instr_req && data_req) begin
      if (PRIO_DATA) begin
        gnt = (starve_cnt == CNT_MAX) ? 2'b01 : 2'b10;
      end else begin
        gnt = last_i ? 2'b10 : 2'b01;
      end
    end else if (instr_req) begin
      gnt = 2'b01;
    end else if (data_req) begin
      gnt = 2'b10;
    end
  end

  // Counter tracks consecutive D wins while I is waiting; any I win or I idle clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      last_i     <= 1'b0;
    end else if (update) begin
      if (!instr_req || gnt[0]) begin
        starve_cnt <= '0;
      end else if (gnt[1] && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (|gnt) begin
        last_i <= gnt[0];
      end
    end
  end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares the single-port data RAM between instruction fetch and the load/store unit;
// one access every two cycles, read data returned through a shared register.
module miriscv_mem_arbiter
  import miriscv_mem_pkg::*;
#(
  parameter bit          PRIO_DATA    = 1'b1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [2:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [2:0]  mem_size_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  arb_state_e  state_q, state_d;
  logic        in_idle;
  logic [1:0]  pick_gnt;
  logic        lat_we;
  logic [2:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_q;
  logic        instr_rvalid_q;
  logic        data_rvalid_q;

  assign in_idle = (state_q == IDLE);

  miriscv_mem_arb_pick #(
    .PRIO_DATA   (PRIO_DATA),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .instr_req(instr_req_i),
    .data_req (data_req_i),
    .update   (in_idle),
    .gnt      (pick_gnt)
  );

  assign instr_gnt_o = in_idle & pick_gnt[0];
  assign data_gnt_o  = in_idle & pick_gnt[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM port is only driven during the single access cycle; zero otherwise.
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_size_o  = 3'd0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    case (state_q)
      IDLE: begin
        if (instr_gnt_o) begin
          state_d = ACC_I;
        end else if (data_gnt_o) begin
          state_d = ACC_D;
        end
      end
      ACC_I: begin
        mem_req_o  = 1'b1;
        mem_size_o = MEM_SIZE_W;
        mem_addr_o = lat_addr;
        state_d    = IDLE;
      end
      ACC_D: begin
        mem_req_o   = 1'b1;
        mem_we_o    = lat_we;
        mem_size_o  = lat_size;
        mem_addr_o  = lat_addr;
        mem_wdata_o = lat_wdata;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_size  <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (instr_gnt_o) begin
      lat_we    <= 1'b0;
      lat_size  <= MEM_SIZE_W;
      lat_addr  <= instr_addr_i;
      lat_wdata <= 32'd0;
    end else if (data_gnt_o) begin
      lat_we    <= data_we_i;
      lat_size  <= data_size_i;
      lat_addr  <= data_addr_i;
      lat_wdata <= data_wdata_i;
    end
  end

  // Writes acknowledge through rvalid but leave the shared read register untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
      rdata_q        <= 32'd0;
    end else begin
      instr_rvalid_q <= (state_q == ACC_I);
      data_rvalid_q  <= (state_q == ACC_D);
      if (state_q == ACC_I || (state_q == ACC_D && !lat_we)) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

  assign instr_rvalid_o = instr_rvalid_q;
  assign data_rvalid_o  = data_rvalid_q;
  assign instr_rdata_o  = rdata_q;
  assign data_rdata_o   = rdata_q;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Bench for miriscv_mem_arbiter: a priority instance and a round-robin instance, each with
// its own RAM, checked every cycle against a transaction-timed reference model.
module tb_miriscv_mem_arbiter;
  import miriscv_mem_pkg::*;

  localparam int STARVE_LIMIT  = 4;
  localparam int RANDOM_CYCLES = 800;

  typedef struct packed {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [2:0]  dsize;
    logic [31:0] daddr;
    logic [31:0] dwdata;
  } drive_t;

  typedef struct packed {
    logic        ig;
    logic        dg;
    logic        irv;
    logic        drv;
    logic        mreq;
    logic        mwe;
    logic [2:0]  msize;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] irdata;
    logic [31:0] drdata;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        instr_req [2];
  logic [31:0] instr_addr [2];
  logic        instr_gnt [2];
  logic        instr_rvalid [2];
  logic [31:0] instr_rdata [2];
  logic        data_req [2];
  logic        data_we [2];
  logic [2:0]  data_size [2];
  logic [31:0] data_addr [2];
  logic [31:0] data_wdata [2];
  logic        data_gnt [2];
  logic        data_rvalid [2];
  logic [31:0] data_rdata [2];
  logic        mem_req [2];
  logic        mem_we [2];
  logic [2:0]  mem_size [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] ram [2][16];
  logic [31:0] mref [2][16];

  drive_t drv [2];
  obs_t   obs [2];

  int free_at [2];
  bit acc_pend [2];
  int acc_cyc [2];
  bit tx_d [2];
  bit tx_we [2];
  logic [2:0]  tx_size [2];
  logic [31:0] tx_addr [2];
  logic [31:0] tx_wdata [2];
  int starve [2];
  bit last_i [2];
  logic [31:0] reg_data [2];

  int tests_run = 0;
  int tests_failed = 0;
  int cycle_num = 0;
  bit reset_next = 1'b1;
  bit random_mode = 1'b0;

  bit gnt_i0 [$];
  int gnt_cyc0 [$];
  bit gnt_i1 [$];
  bit rv_i1 [$];

  miriscv_mem_arbiter #(.PRIO_DATA(1'b1), .STARVE_LIMIT(STARVE_LIMIT)) dut_prio (
    .clk(clk), .reset(reset),
    .instr_req_i(instr_req[0]), .instr_addr_i(instr_addr[0]), .instr_gnt_o(instr_gnt[0]),
    .instr_rvalid_o(instr_rvalid[0]), .instr_rdata_o(instr_rdata[0]),
    .data_req_i(data_req[0]), .data_we_i(data_we[0]), .data_size_i(data_size[0]),
    .data_addr_i(data_addr[0]), .data_wdata_i(data_wdata[0]), .data_gnt_o(data_gnt[0]),
    .data_rvalid_o(data_rvalid[0]), .data_rdata_o(data_rdata[0]),
    .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_size_o(mem_size[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0])
  );

  miriscv_mem_arbiter #(.PRIO_DATA(1'b0), .STARVE_LIMIT(STARVE_LIMIT)) dut_rr (
    .clk(clk), .reset(reset),
    .instr_req_i(instr_req[1]), .instr_addr_i(instr_addr[1]), .instr_gnt_o(instr_gnt[1]),
    .instr_rvalid_o(instr_rvalid[1]), .instr_rdata_o(instr_rdata[1]),
    .data_req_i(data_req[1]), .data_we_i(data_we[1]), .data_size_i(data_size[1]),
    .data_addr_i(data_addr[1]), .data_wdata_i(data_wdata[1]), .data_gnt_o(data_gnt[1]),
    .data_rvalid_o(data_rvalid[1]), .data_rdata_o(data_rdata[1]),
    .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_size_o(mem_size[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1])
  );

  // RAM behaviour: sub-word accesses use the low lanes of the addressed word.
  function automatic logic [31:0] ramRead(input logic [31:0] w, input logic [2:0] sz);
    case (sz)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd2:    return w;
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ramWrite(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return {old[31:8], wd[7:0]};
      3'd1, 3'd5: return {old[31:16], wd[15:0]};
      3'd2:       return wd;
      default:    return old;
    endcase
  endfunction

  assign mem_rdata[0] = ramRead(ram[0][mem_addr[0][3:0]], mem_size[0]);
  assign mem_rdata[1] = ramRead(ram[1][mem_addr[1][3:0]], mem_size[1]);

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cycle_num, observed, expected);
    end
  endtask

  // Reference model: an access granted at cycle n occupies the RAM at n+1 and completes at n+2.
  task automatic modelEval(input int g);
    bit e_ig, e_dg, e_irv, e_drv, e_req, e_we, win_i;
    logic [2:0]  e_size;
    logic [31:0] e_addr, e_wdata;
    string pfx;
    pfx = (g == 0) ? "prio" : "rr";
    obs[g] = '{instr_gnt[g], data_gnt[g], instr_rvalid[g], data_rvalid[g], mem_req[g], mem_we[g],
               mem_size[g], mem_addr[g], mem_wdata[g], instr_rdata[g], data_rdata[g]};
    {e_ig, e_dg, e_irv, e_drv, e_req, e_we} = 6'b0;
    e_size = 3'd0;
    e_addr = 32'd0;
    e_wdata = 32'd0;
    if (reset) begin
      free_at[g] = cycle_num + 1;
      acc_pend[g] = 1'b0;
      starve[g] = 0;
      last_i[g] = 1'b0;
      reg_data[g] = 32'd0;
    end else begin
      if (acc_pend[g] && cycle_num == acc_cyc[g]) begin
        e_req = 1'b1;
        e_we = tx_we[g];
        e_size = tx_size[g];
        e_addr = tx_addr[g];
        e_wdata = tx_wdata[g];
      end
      if (acc_pend[g] && cycle_num == acc_cyc[g] + 1) begin
        if (tx_we[g]) mref[g][tx_addr[g][3:0]] = ramWrite(mref[g][tx_addr[g][3:0]], tx_wdata[g], tx_size[g]);
        else reg_data[g] = ramRead(mref[g][tx_addr[g][3:0]], tx_size[g]);
        if (tx_d[g]) e_drv = 1'b1;
        else e_irv = 1'b1;
        acc_pend[g] = 1'b0;
      end
      if (cycle_num >= free_at[g]) begin
        if (instr_req[g] && data_req[g]) win_i = (g == 0) ? (starve[g] == STARVE_LIMIT) : !last_i[g];
        else win_i = instr_req[g];
        if (g == 0 && !instr_req[g]) starve[g] = 0;
        if (instr_req[g] || data_req[g]) begin
          if (g == 0 && instr_req[g]) starve[g] = win_i ? 0 : ((starve[g] < STARVE_LIMIT) ? starve[g] + 1 : STARVE_LIMIT);
          last_i[g] = win_i;
          e_ig = win_i;
          e_dg = !win_i;
          acc_pend[g] = 1'b1;
          acc_cyc[g] = cycle_num + 1;
          free_at[g] = cycle_num + 2;
          tx_d[g] = !win_i;
          tx_we[g] = win_i ? 1'b0 : data_we[g];
          tx_size[g] = win_i ? MEM_SIZE_W : data_size[g];
          tx_addr[g] = win_i ? instr_addr[g] : data_addr[g];
          tx_wdata[g] = win_i ? 32'd0 : data_wdata[g];
        end
      end
    end
    checkOutput({pfx, " ctl"}, 64'({obs[g].ig, obs[g].dg, obs[g].irv, obs[g].drv, obs[g].mreq, obs[g].mwe, obs[g].msize}),
                64'({e_ig, e_dg, e_irv, e_drv, e_req, e_we, e_size}));
    checkOutput({pfx, " mem_addr"}, 64'(obs[g].maddr), 64'(e_addr));
    checkOutput({pfx, " mem_wdata"}, 64'(obs[g].mwdata), 64'(e_wdata));
    checkOutput({pfx, " rdata"}, {obs[g].irdata, obs[g].drdata}, {reg_data[g], reg_data[g]});
    if (obs[g].ig || obs[g].dg) begin
      if (g == 0) begin
        gnt_i0.push_back(obs[g].ig);
        gnt_cyc0.push_back(cycle_num);
      end else begin
        gnt_i1.push_back(obs[g].ig);
      end
    end
    if (g == 1 && (obs[g].irv || obs[g].drv)) rv_i1.push_back(obs[g].irv);
  endtask

  task automatic applyStimulus(input int g);
    logic [2:0] size_tab [8];
    size_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};
    if (drv[g].ireq && (obs[g].ig || $urandom_range(0, 15) == 0)) begin
      drv[g].ireq = 1'b0;
    end else if (!drv[g].ireq && $urandom_range(0, 1) == 1) begin
      drv[g].ireq = 1'b1;
      drv[g].iaddr = 32'($urandom_range(0, 15));
    end
    if (drv[g].dreq && (obs[g].dg || $urandom_range(0, 15) == 0)) begin
      drv[g].dreq = 1'b0;
    end else if (!drv[g].dreq && $urandom_range(0, 1) == 1) begin
      drv[g].dreq = 1'b1;
      drv[g].dwe = 1'($urandom_range(0, 1));
      drv[g].dsize = size_tab[$urandom_range(0, 7)];
      drv[g].daddr = 32'($urandom_range(0, 15));
      drv[g].dwdata = $urandom;
    end
  endtask

  task automatic driveInputs();
    for (int g = 0; g < 2; g++) begin
      instr_req[g] = drv[g].ireq;
      instr_addr[g] = drv[g].iaddr;
      data_req[g] = drv[g].dreq;
      data_we[g] = drv[g].dwe;
      data_size[g] = drv[g].dsize;
      data_addr[g] = drv[g].daddr;
      data_wdata[g] = drv[g].dwdata;
    end
  endtask

  // Inputs change on the falling edge; RAM writes are applied on the rising edge.
  task automatic stepCycle(input bit mid_reset);
    bit wr_en [2];
    logic [3:0] wr_idx [2];
    logic [31:0] wr_data [2];
    logic [2:0] wr_size [2];
    @(negedge clk);
    cycle_num++;
    reset = reset_next;
    if (random_mode) begin
      applyStimulus(0);
      applyStimulus(1);
    end
    driveInputs();
    #1;
    modelEval(0);
    modelEval(1);
    #1;
    if (mid_reset) begin
      reset = 1'b1;
      reset_next = 1'b1;
      #1;
      checkOutput("midreset mem_we", 64'(mem_we[0]), 64'd0);
      checkOutput("midreset mem_req", 64'(mem_req[0]), 64'd0);
    end else begin
      #1;
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      wr_en[g] = mem_req[g] && mem_we[g];
      wr_idx[g] = mem_addr[g][3:0];
      wr_data[g] = mem_wdata[g];
      wr_size[g] = mem_size[g];
    end
    @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      if (wr_en[g]) ram[g][wr_idx[g]] = ramWrite(ram[g][wr_idx[g]], wr_data[g], wr_size[g]);
    end
  endtask

  task automatic waitGrant(input int g, input bit is_data, output int t);
    bit got;
    got = 1'b0;
    t = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      stepCycle(1'b0);
      if (is_data ? obs[g].dg : obs[g].ig) begin
        got = 1'b1;
        t = cycle_num;
      end
    end
    checkOutput(is_data ? "grant D" : "grant I", 64'(got), 64'd1);
    if (is_data) drv[g].dreq = 1'b0;
    else drv[g].ireq = 1'b0;
  endtask

  task automatic applyReset();
    random_mode = 1'b0;
    drv[0] = '0;
    drv[1] = '0;
    reset_next = 1'b1;
    stepCycle(1'b0);
    stepCycle(1'b0);
    reset_next = 1'b0;
    stepCycle(1'b0);
  endtask

  initial begin
    int t;
    bit exp3 [10];
    bit exp4 [4];
    exp3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp4 = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 16; i++) begin
        ram[g][i] = $urandom;
        mref[g][i] = ram[g][i];
      end
    end
    drv[0] = '0;
    drv[1] = '0;
    driveInputs();
    applyReset();
    checkOutput("reset ctl", 64'({instr_gnt[0], data_gnt[0], instr_rvalid[0], data_rvalid[0], mem_req[0]}), 64'd0);

    random_mode = 1'b1;
    repeat (RANDOM_CYCLES) stepCycle(1'b0);
    random_mode = 1'b0;
    drv[0] = '0;
    drv[1] = '0;
    repeat (4) stepCycle(1'b0);

    // D read of a word
    applyReset();
    ram[0][5] = 32'hDEADBEEF;
    mref[0][5] = 32'hDEADBEEF;
    drv[0].dreq = 1'b1; drv[0].dwe = 1'b0; drv[0].dsize = MEM_SIZE_W; drv[0].daddr = 32'd5;
    waitGrant(0, 1'b1, t);
    stepCycle(1'b0);
    checkOutput("t1 access", 64'({obs[0].mreq, obs[0].maddr}), 64'({1'b1, 32'd5}));
    stepCycle(1'b0);
    checkOutput("t1 rvalid", 64'({obs[0].drv, obs[0].irv}), 64'b10);
    checkOutput("t1 rdata", 64'(obs[0].drdata), 64'h0000_0000_DEAD_BEEF);

    // Byte write followed by fetch of the same word
    applyReset();
    ram[0][3] = 32'h11223344;
    mref[0][3] = 32'h11223344;
    drv[0].dreq = 1'b1; drv[0].dwe = 1'b1; drv[0].dsize = MEM_SIZE_SB;
    drv[0].daddr = 32'd3; drv[0].dwdata = 32'h000000AA;
    waitGrant(0, 1'b1, t);
    stepCycle(1'b0);
    checkOutput("t2 write we", 64'({obs[0].mreq, obs[0].mwe}), 64'b11);
    stepCycle(1'b0);
    checkOutput("t2 ram word", 64'(ram[0][3]), 64'h0000_0000_1122_33AA);
    checkOutput("t2 write ack", 64'(obs[0].drv), 64'd1);
    drv[0].ireq = 1'b1; drv[0].iaddr = 32'd3;
    waitGrant(0, 1'b0, t);
    stepCycle(1'b0);
    checkOutput("t2 fetch we", 64'({obs[0].mreq, obs[0].mwe}), 64'b10);
    stepCycle(1'b0);
    checkOutput("t2 fetch rvalid", 64'(obs[0].irv), 64'd1);
    checkOutput("t2 fetch rdata", 64'(obs[0].irdata), 64'h0000_0000_1122_33AA);

    // Starvation limit with both ports held
    applyReset();
    gnt_i0.delete();
    gnt_cyc0.delete();
    drv[0].ireq = 1'b1; drv[0].iaddr = 32'd2;
    drv[0].dreq = 1'b1; drv[0].dwe = 1'b0; drv[0].dsize = MEM_SIZE_W; drv[0].daddr = 32'd9;
    repeat (21) stepCycle(1'b0);
    drv[0] = '0;
    repeat (3) stepCycle(1'b0);
    checkOutput("t3 grant count", 64'(gnt_i0.size() >= 10), 64'd1);
    for (int i = 0; i < 10; i++) checkOutput($sformatf("t3 order %0d", i), 64'(gnt_i0[i]), 64'(exp3[i]));
    for (int i = 1; i < 10; i++) checkOutput($sformatf("t3 spacing %0d", i), 64'(gnt_cyc0[i] - gnt_cyc0[i-1]), 64'd2);

    // Round-robin alternation and per-port responses
    applyReset();
    gnt_i1.delete();
    rv_i1.delete();
    drv[1].ireq = 1'b1; drv[1].iaddr = 32'd4;
    drv[1].dreq = 1'b1; drv[1].dwe = 1'b0; drv[1].dsize = MEM_SIZE_UH; drv[1].daddr = 32'd6;
    repeat (8) stepCycle(1'b0);
    drv[1] = '0;
    repeat (4) stepCycle(1'b0);
    checkOutput("t4 grant count", 64'(gnt_i1.size() >= 4 && rv_i1.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t4 order %0d", i), 64'(gnt_i1[i]), 64'(exp4[i]));
      checkOutput($sformatf("t4 rvalid port %0d", i), 64'(rv_i1[i]), 64'(exp4[i]));
    end

    // Asynchronous reset during a write access
    applyReset();
    ram[0][7] = 32'd0;
    mref[0][7] = 32'd0;
    drv[0].dreq = 1'b1; drv[0].dwe = 1'b1; drv[0].dsize = MEM_SIZE_W;
    drv[0].daddr = 32'd7; drv[0].dwdata = 32'hCAFEF00D;
    waitGrant(0, 1'b1, t);
    stepCycle(1'b1);
    stepCycle(1'b0);
    checkOutput("t5 no rvalid", 64'({obs[0].drv, obs[0].irv, obs[0].mreq}), 64'd0);
    reset_next = 1'b0;
    repeat (2) stepCycle(1'b0);
    checkOutput("t5 ram untouched", 64'(ram[0][7]), 64'd0);

    // Request pulsed outside IDLE is ignored
    applyReset();
    drv[0].dreq = 1'b1; drv[0].dwe = 1'b0; drv[0].dsize = MEM_SIZE_W; drv[0].daddr = 32'd1;
    waitGrant(0, 1'b1, t);
    drv[0].ireq = 1'b1; drv[0].iaddr = 32'd8;
    stepCycle(1'b0);
    checkOutput("t6 pulse no gnt", 64'(obs[0].ig), 64'd0);
    drv[0].ireq = 1'b0;
    stepCycle(1'b0);
    checkOutput("t6 dropped no gnt", 64'(obs[0].ig), 64'd0);
    stepCycle(1'b0);
    checkOutput("t6 no access", 64'(obs[0].mreq), 64'd0);
    drv[0].ireq = 1'b1; drv[0].iaddr = 32'd8;
    waitGrant(0, 1'b0, t);
    repeat (3) stepCycle(1'b0);

    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 16; i++) checkOutput($sformatf("final ram %0d/%0d", g, i), 64'(ram[g][i]), 64'(mref[g][i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
